// File: rtl/rx_tx_pkg.sv
// rx_tx_pkg: line-format constants and FSM states shared by the serial receiver and transmitter.
package rx_tx_pkg;
  typedef enum logic [2:0] {IDLE, START, SIZE, DATA, CRC, STOP} state_t;
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT = 1'b0;
  localparam int FRAME_W = 128;
endpackage

// File: rtl/receiver_if.sv
// receiver_if: serial line in, parallel frame out, for the single-wire frame receiver.
interface receiver_if;
  import rx_tx_pkg::*;
  logic RX;
  logic [7:0] baudrate;
  logic RXI;
  logic rf;
  logic [3:0] framesize;
  logic [FRAME_W-1:0] framebits;
  logic crcerr;
  logic framerr;
  modport master (output RX, baudrate, input RXI, rf, framesize, framebits, crcerr, framerr);
  modport slave (input RX, baudrate, output RXI, rf, framesize, framebits, crcerr, framerr);
endinterface

// File: rtl/crc.sv
// crc: serial CRC-8 (x^8+x^2+x+1), MSb first, one bit per enabled cycle; shared with the transmitter.
module crc (
  input  logic       enable,
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic [7:0] out
);
  logic [7:0] r_crc;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_crc <= '0;
    else if (enable) r_crc <= {r_crc[6:0], 1'b0} ^ ((r_crc[7] ^ in) ? 8'h07 : 8'h00);
  assign out = r_crc;
endmodule

// File: rtl/receiver.sv
// receiver: recovers start/size/data/crc/stop frames from RX and presents them in parallel with an rf strobe.
module receiver
  import rx_tx_pkg::*;
#(
  parameter int MAXBYTES = 16
) (
  input logic clk,
  input logic reset,
  receiver_if.slave bus
);
  localparam int FW = 8 * MAXBYTES;
  localparam int IW = $clog2(FW);
  state_t r_state;
  logic r_rx_s1, r_rx_s2, r_rx_d, r_crc_rst;
  logic [7:0] r_baud_l, r_bcnt, r_rxcrc;
  logic [3:0] r_size, r_byte;
  logic [2:0] r_bit;
  logic [FW-1:0] r_shadow, r_framebits;
  logic r_rxi, r_rf, r_crcerr, r_framerr;
  logic [3:0] r_framesize;
  logic w_rx, w_smp, w_bnd, w_edge, w_crc_en, w_last, w_crc_rst;
  logic [3:0] w_size;
  logic [7:0] w_crc;
  logic [IW-1:0] w_idx;
  assign w_rx = r_rx_s2;
  assign w_smp = r_bcnt == (r_baud_l >> 1);
  assign w_bnd = r_bcnt == r_baud_l - 8'd1;
  assign w_edge = w_rx == START_BIT && r_rx_d != START_BIT;
  // sample and boundary can coincide at baudrate 2, so the boundary decision sees the fresh bit
  assign w_size = w_smp ? {r_size[2:0], w_rx} : r_size;
  assign w_last = r_byte == r_size - 4'd1;
  assign w_crc_en = w_smp && (r_state == SIZE || r_state == DATA);
  assign w_crc_rst = reset | r_crc_rst;
  assign w_idx = IW'(8 * (MAXBYTES - 1 - int'(r_byte)) + int'(r_bit));
  crc crccalc (.enable(w_crc_en), .clk(clk), .reset(w_crc_rst), .in(w_rx), .out(w_crc));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      {r_rx_s1, r_rx_s2, r_rx_d, r_crc_rst} <= '0;
      {r_baud_l, r_bcnt, r_rxcrc, r_size, r_byte, r_bit} <= '0;
      {r_shadow, r_framebits, r_framesize} <= '0;
      {r_rf, r_crcerr, r_framerr} <= '0;
      r_rxi <= 1'b1;
    end else begin
      r_rx_s1 <= bus.RX;
      r_rx_s2 <= r_rx_s1;
      r_rx_d <= r_rx_s2;
      r_rf <= 1'b0;
      r_crc_rst <= 1'b0;
      if (r_state != IDLE) r_bcnt <= w_bnd ? '0 : r_bcnt + 8'd1;
      case (r_state)
        IDLE: if (w_edge) begin
          r_baud_l <= bus.baudrate;
          r_bcnt <= 8'd1;
          r_crc_rst <= 1'b1;
          r_rxi <= 1'b0;
          r_shadow <= '0;
          r_state <= START;
        end
        START: if (w_smp && w_rx != START_BIT) begin
          r_state <= IDLE;
          r_rxi <= 1'b1;
        end else if (w_bnd) begin
          r_state <= SIZE;
          r_bit <= '0;
        end
        SIZE: begin
          if (w_smp) r_size <= w_size;
          if (w_bnd) begin
            r_bit <= r_bit != 3'd3 ? r_bit + 3'd1 : (w_size == 4'd0 ? 3'd0 : 3'd7);
            r_state <= r_bit != 3'd3 ? SIZE : (w_size == 4'd0 ? CRC : DATA);
            r_byte <= '0;
          end
        end
        DATA: begin
          if (w_smp) r_shadow[w_idx] <= w_rx;
          if (w_bnd) begin
            r_bit <= r_bit == 3'd0 && w_last ? 3'd0 : r_bit - 3'd1;
            r_byte <= r_bit == 3'd0 ? r_byte + 4'd1 : r_byte;
            r_state <= r_bit == 3'd0 && w_last ? CRC : DATA;
          end
        end
        CRC: begin
          if (w_smp) r_rxcrc <= {r_rxcrc[6:0], w_rx};
          if (w_bnd) begin
            r_bit <= r_bit + 3'd1;
            r_state <= r_bit == 3'd7 ? STOP : CRC;
          end
        end
        STOP: if (w_smp) begin
          r_framesize <= r_size;
          r_framebits <= r_shadow;
          r_crcerr <= r_rxcrc != w_crc;
          r_framerr <= w_rx != STOP_BIT;
          r_rf <= 1'b1;
          r_rxi <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign bus.RXI = r_rxi;
  assign bus.rf = r_rf;
  assign bus.framesize = r_framesize;
  assign bus.framebits = r_framebits;
  assign bus.crcerr = r_crcerr;
  assign bus.framerr = r_framerr;
endmodule
